// File: rtl/r_fifo_am.sv
// ---------------------------------------------------------------------------
// r_fifo_am -- asynchronous FIFO for AXI R-channel beats.
//
// Carries packed R beats (RLAST[0], RRESP[2:1], RDATA[34:3], RID[38:35]) from
// the AXI clock domain (wclk) to the master clock domain (rclk). Pointers are
// ADDR_W+1 bits wide. They cross domains only as registered Gray code through
// 2-flop synchronizers. Full and empty status is therefore pessimistic.
//
// Parameters
//   ADDR_W   log2 of the storage depth (default 2 -> 4 entries)
//   DATA_W   packed beat width (default 39)
//
// Ports (write side, wclk)
//   wclk     write-side clock
//   wrst     synchronous active-high reset for the write side
//   s_valid  a beat is offered on s_data
//   s_data   packed R beat
//   s_ready  the FIFO has room; depends on registers only
//   wcount   occupancy as seen from the write side (0..DEPTH)
// Ports (read side, rclk)
//   rclk     read-side clock, asynchronous to wclk
//   rrst     synchronous active-high reset for the read side
//   m_valid  the head beat is presented on m_data
//   m_data   head beat; all zeros while m_valid is low
//   m_ready  the master consumes the head beat this cycle
// ---------------------------------------------------------------------------
module r_fifo_am #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 39
) (
    input  logic              wclk,
    input  logic              wrst,
    input  logic              rclk,
    input  logic              rrst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [ADDR_W:0]   wcount,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PW    = ADDR_W + 1;

    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Write-domain state
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]   wgray_q;
    logic [ADDR_W:0]   rgray_s1_q, rgray_s2_q;
    logic [ADDR_W:0]   rptr_sync;
    logic              full;
    logic              push;

    // Read-domain state
    logic [ADDR_W:0]   rptr_q, rptr_d;
    logic [ADDR_W:0]   rgray_q;
    logic [ADDR_W:0]   wgray_s1_q, wgray_s2_q;
    logic [ADDR_W:0]   wptr_sync;
    logic              empty;
    logic              pop;

    // ---- write side: status from the synchronized read pointer ----
    assign rptr_sync = gray2bin(rgray_s2_q);
    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign full    = (wptr_q[ADDR_W] != rptr_sync[ADDR_W]) &&
                     (wptr_q[ADDR_W-1:0] == rptr_sync[ADDR_W-1:0]);
    assign s_ready = !full;
    assign wcount  = wptr_q - rptr_sync;
    assign push    = s_valid && !full;

    always_comb begin
        wptr_d = wptr_q;
        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end
    end

    // Gray pointer is registered from the next-state binary value, so it
    // changes in the same cycle as wptr_q and is glitch-free for the crossing.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wptr_q     <= '0;
            wgray_q    <= '0;
            rgray_s1_q <= '0;
            rgray_s2_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q     <= wptr_d;
            wgray_q    <= bin2gray(wptr_d);
            rgray_s1_q <= rgray_q;
            rgray_s2_q <= rgray_s1_q;
            if (push) begin
                mem_q[wptr_q[ADDR_W-1:0]] <= s_data;
            end
        end
    end

    // ---- read side: status from the synchronized write pointer ----
    assign wptr_sync = gray2bin(wgray_s2_q);
    assign empty     = (rptr_q == wptr_sync);
    assign m_valid   = !empty;
    // The head entry cannot be rewritten while it is unread (full blocks the
    // writer), so m_data is stable for as long as the beat is not popped.
    assign m_data    = m_valid ? mem_q[rptr_q[ADDR_W-1:0]] : '0;
    assign pop       = m_valid && m_ready;

    always_comb begin
        rptr_d = rptr_q;
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rptr_q     <= '0;
            rgray_q    <= '0;
            wgray_s1_q <= '0;
            wgray_s2_q <= '0;
        end else begin
            rptr_q     <= rptr_d;
            rgray_q    <= bin2gray(rptr_d);
            wgray_s1_q <= wgray_q;
            wgray_s2_q <= wgray_s1_q;
        end
    end

endmodule

// File: tb/tb_r_fifo_am.sv
// ---------------------------------------------------------------------------
// tb_r_fifo_am -- self-checking bench for r_fifo_am.
// wclk period 10, rclk period 28 (about 100 MHz / 36 MHz).
// ---------------------------------------------------------------------------
module tb_r_fifo_am;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 39;

    logic              wclk = 1'b0;
    logic              rclk = 1'b0;
    logic              wrst;
    logic              rrst;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic [ADDR_W:0]   wcount;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5  wclk = ~wclk;
    always #14 rclk = ~rclk;

    r_fifo_am #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .wclk    (wclk),
        .wrst    (wrst),
        .rclk    (rclk),
        .rrst    (rrst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .wcount  (wcount),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready)
    );

    typedef struct {
        logic              v;
        logic [DATA_W-1:0] d;
        logic              exp_rdy;
        logic [ADDR_W:0]   exp_wc;
    } fill_vec_t;

    // Beat k: RID=k[3:0], RDATA=C0DE0000+k, RRESP=k[1:0], RLAST=k[0]
    function automatic logic [DATA_W-1:0] beat(input int k);
        logic [31:0] kk;
        kk = k;
        return {kk[3:0], 32'(32'hC0DE0000 + kk), kk[1:0], kk[0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge wclk);
        wrst    = 1'b1;
        rrst    = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        repeat (8) @(negedge wclk);
        wrst = 1'b0;
        rrst = 1'b0;
    endtask

    task automatic wait_mvalid(input int max_edges, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_edges; i++) begin
            @(posedge rclk);
            #1;
            if (m_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_wempty(input int max_edges, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_edges; i++) begin
            @(posedge wclk);
            #1;
            if (wcount == '0 && s_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Returns 1 time unit after the wclk edge that performs the push.
    task automatic push_one(input logic [DATA_W-1:0] d);
        @(negedge wclk);
        check("push_ready", 64'(s_ready), 64'd1);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge wclk);
        #1;
        s_valid = 1'b0;
    endtask

    // Returns 1 time unit after the rclk edge that performs the pop.
    task automatic pop_one();
        @(negedge rclk);
        m_ready = 1'b1;
        @(posedge rclk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic run_phase(input int base, input int wp, input int rp);
        int sent;
        int got;
        bit ok;
        sent = 0;
        got  = 0;
        fork
            begin
                bit acc;
                acc = 1'b0;
                for (int c = 0; c < 3000 && sent < 20; c++) begin
                    @(negedge wclk);
                    if (acc) s_valid = 1'b0;
                    if (!s_valid) s_valid = ($urandom_range(0, 3) < wp);
                    s_data = beat(base + sent);
                    acc = s_valid && s_ready;
                    if (acc) sent++;
                end
                @(negedge wclk);
                s_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 3000 && got < 20; c++) begin
                    @(negedge rclk);
                    m_ready = ($urandom_range(0, 3) < rp);
                    if (m_valid && m_ready) begin
                        check("wrap_beat", 64'(m_data), 64'(beat(base + got)));
                        got++;
                    end
                end
                @(negedge rclk);
                m_ready = 1'b0;
            end
        join
        check("wrap_sent", 64'(sent), 64'd20);
        check("wrap_got", 64'(got), 64'd20);
        wait_wempty(6, ok);
        check("wrap_wempty", 64'(ok), 64'd1);
        repeat (4) @(negedge rclk);
        check("wrap_no_dup", 64'(m_valid), 64'd0);
    endtask

    // Absolute time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1, "time limit reached");
    end

    initial begin
        fill_vec_t         fv [7];
        logic [DATA_W-1:0] sb_beat;
        logic [DATA_W-1:0] fill_d [5];
        bit                ok;
        bit                stable;
        bit                alone;
        int                got;

        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        wrst    = 1'b1;
        rrst    = 1'b1;

        for (int i = 0; i < 5; i++) fill_d[i] = beat(101 + i);
        // Rows give the status expected before the row's inputs are applied.
        fv[0] = '{1'b1, fill_d[0], 1'b1, 3'd0};
        fv[1] = '{1'b1, fill_d[1], 1'b1, 3'd1};
        fv[2] = '{1'b1, fill_d[2], 1'b1, 3'd2};
        fv[3] = '{1'b1, fill_d[3], 1'b1, 3'd3};
        fv[4] = '{1'b1, fill_d[4], 1'b0, 3'd4};
        fv[5] = '{1'b1, fill_d[4], 1'b0, 3'd4};
        fv[6] = '{1'b0, fill_d[4], 1'b0, 3'd4};

        // ---- reset state ----
        do_reset();
        @(negedge rclk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        @(negedge wclk);
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_wcount", 64'(wcount), 64'd0);

        // ---- single beat ----
        sb_beat = {4'h5, 32'hDEADBEEF, 2'b00, 1'b1};
        push_one(sb_beat);
        @(posedge rclk);
        #1;
        check("sb_not_early", 64'(m_valid), 64'd0);
        wait_mvalid(3, ok);
        check("sb_valid_in_time", 64'(ok), 64'd1);
        check("sb_data", 64'(m_data), 64'(sb_beat));
        pop_one();
        check("sb_valid_after_pop", 64'(m_valid), 64'd0);
        check("sb_data_after_pop", 64'(m_data), 64'd0);
        wait_wempty(6, ok);
        check("sb_wcount_back", 64'(ok), 64'd1);

        // ---- fill with m_ready low, while watching head stability ----
        fork
            begin
                for (int i = 0; i < 7; i++) begin
                    @(negedge wclk);
                    check("fill_s_ready", 64'(s_ready), 64'(fv[i].exp_rdy));
                    check("fill_wcount", 64'(wcount), 64'(fv[i].exp_wc));
                    s_valid = fv[i].v;
                    s_data  = fv[i].d;
                end
            end
            begin
                wait_mvalid(8, ok);
                check("stall_valid", 64'(ok), 64'd1);
                check("stall_head", 64'(m_data), 64'(fill_d[0]));
                stable = 1'b1;
                repeat (10) begin
                    @(negedge rclk);
                    if (!m_valid || m_data !== fill_d[0]) stable = 1'b0;
                end
                check("stall_hold", 64'(stable), 64'd1);
            end
        join
        @(negedge wclk);
        check("fill_full_wcount", 64'(wcount), 64'd4);

        // ---- drain ----
        got = 0;
        @(negedge rclk);
        m_ready = 1'b1;
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (c > 0) @(negedge rclk);
            if (m_valid) begin
                check("drain_beat", 64'(m_data), 64'(fill_d[got]));
                got++;
            end
        end
        check("drain_count", 64'(got), 64'd4);
        @(posedge rclk);
        #1;
        check("drain_m_valid_low", 64'(m_valid), 64'd0);
        wait_wempty(3, ok);
        check("drain_wempty_in_time", 64'(ok), 64'd1);
        @(negedge rclk);
        check("drain_ready_no_effect", 64'(m_valid), 64'd0);
        m_ready = 1'b0;

        // ---- wrap under 1:3 and 3:1 traffic ----
        run_phase(0, 1, 3);
        run_phase(20, 3, 1);

        // ---- reset with beats stored ----
        for (int i = 0; i < 3; i++) push_one(beat(200 + i));
        wait_mvalid(6, ok);
        check("rs_stored_valid", 64'(ok), 64'd1);
        @(negedge wclk);
        check("rs_stored_wcount", 64'(wcount), 64'd3);
        do_reset();
        @(negedge rclk);
        check("rs_m_valid", 64'(m_valid), 64'd0);
        check("rs_m_data", 64'(m_data), 64'd0);
        @(negedge wclk);
        check("rs_s_ready", 64'(s_ready), 64'd1);
        check("rs_wcount", 64'(wcount), 64'd0);
        push_one(beat(300));
        wait_mvalid(4, ok);
        check("rs_new_valid", 64'(ok), 64'd1);
        check("rs_new_data", 64'(m_data), 64'(beat(300)));
        pop_one();
        alone = !m_valid;
        repeat (6) begin
            @(negedge rclk);
            if (m_valid) alone = 1'b0;
        end
        check("rs_new_alone", 64'(alone), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
